// File: rtl/permute_round_ctrl.sv
// Round/step sequencer for the 25-bit 5x5 permutation datapath.
// Loads the input line, walks NUM_STEPS steps per round for NUM_ROUNDS rounds, then pulses done.
module permute_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int NUM_STEPS  = 5,
  parameter int ROUND_W    = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 hold_i,
  output logic                 ready_o,
  output logic                 load_en_o,
  output logic [NUM_STEPS-1:0] step_en_o,
  output logic                 state_we_o,
  output logic [ROUND_W-1:0]   round_idx_o,
  output logic                 done_o
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic                last_step, last_round, stepping;

  assign last_step  = (step_q == STEP_W'(NUM_STEPS - 1));
  assign last_round = (round_q == ROUND_W'(NUM_ROUNDS - 1));
  assign stepping   = (state_q == RUN) && !hold_i;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: begin
        step_d  = '0;
        round_d = '0;
        state_d = RUN;
      end
      RUN: if (!hold_i) begin
        if (last_step) begin
          step_d = '0;
          // Round stays at its terminal value through DONE for the constant lookup.
          if (last_round) state_d = DONE;
          else            round_d = round_q + ROUND_W'(1);
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        step_d  = '0;
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  // hold gates the step strobe in the same cycle so a stalled step is replayed.
  assign step_en_o   = stepping ? (NUM_STEPS'(1) << step_q) : '0;
  assign state_we_o  = stepping;
  assign ready_o     = (state_q == IDLE);
  assign load_en_o   = (state_q == LOAD);
  assign done_o      = (state_q == DONE);
  assign round_idx_o = round_q;

endmodule

// File: tb/tb_permute_round_ctrl.sv
// Scoreboard bench for permute_round_ctrl: stimulus queues expected LOAD/STEP/DONE/IDLE
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_permute_round_ctrl;
  localparam int NR = 24;
  localparam int NS = 5;
  localparam int RW = 5;
  localparam int K_LOAD = 0, K_STEP = 1, K_DONE = 2, K_IDLE = 3;

  typedef struct {
    int kind;
    int cyc;
    int step;
    int round;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, start1, hold;
  logic          ready, load_en, state_we, done;
  logic [NS-1:0] step_en;
  logic [RW-1:0] round_idx;
  logic          ready1, load_en1, state_we1, done1;
  logic [NS-1:0] step_en1;
  logic [RW-1:0] round_idx1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   in_run = 1'b0;
  int   last_round = 0;
  int   swaps = 0;
  exp_t q[$];
  int   q1[$];

  permute_round_ctrl #(.NUM_ROUNDS(NR), .NUM_STEPS(NS), .ROUND_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
    .ready_o(ready), .load_en_o(load_en), .step_en_o(step_en),
    .state_we_o(state_we), .round_idx_o(round_idx), .done_o(done));

  permute_round_ctrl #(.NUM_ROUNDS(1), .NUM_STEPS(NS), .ROUND_W(RW)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .hold_i(hold),
    .ready_o(ready1), .load_en_o(load_en1), .step_en_o(step_en1),
    .state_we_o(state_we1), .round_idx_o(round_idx1), .done_o(done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int c, input int s, input int r);
    exp_t e;
    e.kind = kind; e.cyc = c; e.step = s; e.round = r;
    q.push_back(e);
  endtask

  // Expected run for a start sampled at t0; hold_len stall cycles inserted before step hold_k.
  task automatic push_run(input int t0, input int n_steps, input int hold_k,
                          input int hold_len, input bit with_done);
    int extra;
    push(K_LOAD, t0 + 1, 0, 0);
    for (int k = 0; k < n_steps; k++) begin
      extra = (k >= hold_k) ? hold_len : 0;
      push(K_STEP, t0 + 2 + k + extra, k % NS, k / NS);
    end
    if (with_done) begin
      extra = (hold_k < NR * NS) ? hold_len : 0;
      push(K_DONE, t0 + 2 + NR * NS + extra, 0, NR - 1);
      push(K_IDLE, t0 + 3 + NR * NS + extra, 0, 0);
    end
  endtask

  // Main scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      int        akind;
      exp_t      e;
      bit        ok;
      logic [NS-1:0] exp_se;
      akind = load_en ? K_LOAD : done ? K_DONE : (step_en != '0) ? K_STEP : K_IDLE;

      checks++;
      if (state_we !== (|step_en) || !$onehot0(step_en)) begin
        errors++;
        $display("FAIL strobe cyc=%0d: step_en=%b state_we=%b, want one-hot0 and state_we==|step_en",
                 cyc, step_en, state_we);
      end

      if (in_run && hold && !load_en && !done) begin
        checks++;
        if (step_en !== '0 || state_we !== 1'b0 || round_idx !== RW'(last_round)) begin
          errors++;
          $display("FAIL hold cyc=%0d: step_en=%b state_we=%b round=%0d, want 0 0 %0d",
                   cyc, step_en, state_we, round_idx, last_round);
        end
      end

      if ((q.size() > 0 && q[0].kind == K_IDLE && q[0].cyc == cyc) || akind != K_IDLE) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected cyc=%0d: got kind=%0d step_en=%b done=%b, want nothing",
                   cyc, akind, step_en, done);
        end else begin
          e = q.pop_front();
          exp_se = 5'b00001 << e.step;
          ok = (akind == e.kind) && (cyc == e.cyc);
          case (e.kind)
            K_LOAD: begin
              ok = ok && !ready && step_en == '0 && round_idx == '0 && !done;
              in_run = 1'b1;
              swaps = 0;
            end
            K_STEP: begin
              ok = ok && step_en == exp_se && round_idx == RW'(e.round) && !ready;
              last_round = e.round;
              if (step_en[2]) swaps++;
            end
            K_DONE: begin
              ok = ok && !ready && !load_en && round_idx == RW'(e.round) && swaps == NR;
              in_run = 1'b0;
            end
            default: begin
              ok = ok && ready && !load_en && step_en == '0 && !state_we &&
                   round_idx == '0 && !done;
              in_run = 1'b0;
            end
          endcase
          if (!ok) begin
            errors++;
            $display("FAIL event cyc=%0d: got kind=%0d step_en=%b round=%0d ready=%b swaps=%0d, want kind=%0d cyc=%0d step_en=%b round=%0d swaps=%0d",
                     cyc, akind, step_en, round_idx, ready, swaps,
                     e.kind, e.cyc, (e.kind == K_STEP) ? exp_se : '0, e.round, NR);
          end
        end
      end
    end
  end

  // Single-round instance: only the done timing is scored
  always @(negedge clk) begin
    if (mon_en && done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL done1 cyc=%0d: got unexpected done, want none", cyc);
      end else if (q1[0] != cyc) begin
        errors++;
        $display("FAIL done1 cyc=%0d: got done at %0d, want %0d", cyc, cyc, q1[0]);
        void'(q1.pop_front());
      end else begin
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; hold = 1'b0;
    goto(2);
    rst = 1'b0;
    push(K_IDLE, 2, 0, 0);
    mon_en = 1'b1;

    // Plain run, plus single-round instance started alongside
    t0 = cyc + 2;
    push_run(t0, NR * NS, NR * NS, 0, 1'b1);
    q1.push_back(t0 + 7);
    goto(t0); start = 1'b1; start1 = 1'b1;
    goto(t0 + 1); start = 1'b0; start1 = 1'b0;
    goto(t0 + 124);

    // Hold for 3 cycles at round 7 step 2
    t0 = cyc + 1;
    push_run(t0, NR * NS, 7 * NS + 2, 3, 1'b1);
    goto(t0); start = 1'b1;
    goto(t0 + 1); start = 1'b0;
    goto(t0 + 39); hold = 1'b1;
    goto(t0 + 42); hold = 1'b0;
    goto(t0 + 127);

    // Start re-pulsed mid-run is ignored
    t0 = cyc + 1;
    push_run(t0, NR * NS, NR * NS, 0, 1'b1);
    goto(t0); start = 1'b1;
    goto(t0 + 1); start = 1'b0;
    goto(t0 + 50); start = 1'b1;
    goto(t0 + 51); start = 1'b0;
    goto(t0 + 124);

    // Reset at round 10 aborts without done; then a full run
    t0 = cyc + 1;
    push_run(t0, 10 * NS + 1, NR * NS, 0, 1'b0);
    goto(t0); start = 1'b1;
    goto(t0 + 1); start = 1'b0;
    goto(t0 + 52); rst = 1'b1;
    goto(t0 + 53); rst = 1'b0;
    push(K_IDLE, t0 + 53, 0, 0);
    t0 = t0 + 55;
    push_run(t0, NR * NS, NR * NS, 0, 1'b1);
    goto(t0); start = 1'b1;
    goto(t0 + 1); start = 1'b0;
    goto(t0 + 124);

    // Start held high: back-to-back permutations
    t0 = cyc + 1;
    push_run(t0, NR * NS, NR * NS, 0, 1'b1);
    push_run(t0 + 123, NR * NS, NR * NS, 0, 1'b1);
    goto(t0); start = 1'b1;
    goto(t0 + 124); start = 1'b0;
    goto(t0 + 250);

    goto(cyc + 3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen (first kind=%0d cyc=%0d), want 0",
               q.size(), q[0].kind, q[0].cyc);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL drain1: %0d expected done pulses never seen, want 0", q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
